// File: rtl/barrel_shifter.sv
// barrel_shifter: log2(WIDTH)-stage shift/rotate network with a one-cycle registered output
module barrel_shifter #(
  parameter int WIDTH = 8,
  parameter bit ROTATE = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] n,
  input  logic                     lr,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid
);
  localparam int L = $clog2(WIDTH);
  logic [WIDTH-1:0] s [0:L];
  assign s[0] = in_data;
  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int D = 1 << k;
    logic [WIDTH-1:0] l, r;
    // in rotate mode the bits pushed off one end wrap in at the other
    assign l = (s[k] << D) | (ROTATE ? s[k] >> (WIDTH - D) : '0);
    assign r = (s[k] >> D) | (ROTATE ? s[k] << (WIDTH - D) : '0);
    assign s[k+1] = n[k] ? (lr ? l : r) : s[k];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_data <= s[L];
    end
  end
endmodule

// File: tb/tb_barrel_shifter.sv
// tb_barrel_shifter: randomized and directed checks of shift (ROTATE=0) and rotate (ROTATE=1) instances
module tb_barrel_shifter;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, lr = 1'b0;
  logic [7:0] in_data = '0;
  logic [2:0] n = '0;
  logic [7:0] d0, d1;
  logic v0, v1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  barrel_shifter #(.WIDTH(8), .ROTATE(1'b0)) u_shift (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_data(in_data), .n(n), .lr(lr), .out_data(d0), .out_valid(v0));
  barrel_shifter #(.WIDTH(8), .ROTATE(1'b1)) u_rot (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_data(in_data), .n(n), .lr(lr), .out_data(d1), .out_valid(v1));
  function automatic logic [7:0] model(input logic [7:0] d, input int sh, input bit left, input bit rot);
    logic [7:0] r;
    int j;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      j = left ? i + sh : i - sh;
      if (rot) j = (j + 8) % 8;
      if (j >= 0 && j < 8) r[j] = d[i];
    end
    return r;
  endfunction
  task automatic drive(input logic [7:0] d, input logic [2:0] nn, input logic l, input logic v);
    @(negedge clk);
    in_data = d; n = nn; lr = l; in_valid = v;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #1;
    checks++;
    if (d0 !== 8'h00 || v0 !== 1'b0 || d1 !== 8'h00 || v1 !== 1'b0) begin
      errors++; $display("FAIL reset_init: got %b/%b %b/%b want 00000000/0", d0, v0, d1, v1);
    end
    @(negedge clk); rst = 1'b0;
    drive(8'hA5, 3'd1, 1'b1, 1'b1);
    checks++;
    if (v0 !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", v0); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (d0 !== 8'h00 || v0 !== 1'b0 || d1 !== 8'h00 || v1 !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %b/%b %b/%b want 00000000/0", d0, v0, d1, v1);
    end
    @(posedge clk); #1;
    checks++;
    if (d0 !== 8'h00 || v0 !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b/%b want 00000000/0", d0, v0); end
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    drive(8'h3C, 3'd2, 1'b0, 1'b0);
    checks++;
    if (v0 !== 1'b0 || d0 !== 8'h00) begin errors++; $display("FAIL no_spurious: got %b/%b want 00000000/0", d0, v0); end
    drive(8'h3C, 3'd2, 1'b0, 1'b1);
    checks++;
    if (v0 !== 1'b1 || d0 !== 8'h0F || v1 !== 1'b1 || d1 !== 8'h0F) begin
      errors++; $display("FAIL first_after_reset: got %b/%b %b/%b want 00001111/1", d0, v0, d1, v1);
    end
  endtask
  task automatic test_directed;
    logic [7:0] ev [0:5][0:1];
    logic [7:0] dv [0:5];
    logic [2:0] nv [0:5];
    logic lv [0:5];
    dv = '{8'b10110011, 8'b10110011, 8'b11110000, 8'b11110000, 8'b10000001, 8'b10000001};
    nv = '{3'd3, 3'd2, 3'd0, 3'd0, 3'd7, 3'd7};
    lv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    ev = '{'{8'b00010110, 8'b01110110}, '{8'b11001100, 8'b11001110}, '{8'b11110000, 8'b11110000},
           '{8'b11110000, 8'b11110000}, '{8'b10000000, 8'b11000000}, '{8'b00000001, 8'b00000011}};
    for (int i = 0; i < 6; i++) begin
      drive(dv[i], nv[i], lv[i], 1'b1);
      checks++;
      if (d0 !== ev[i][0] || v0 !== 1'b1) begin
        errors++; $display("FAIL directed_shift[%0d]: got %b/%b want %b/1", i, d0, v0, ev[i][0]);
      end
      checks++;
      if (d1 !== ev[i][1] || v1 !== 1'b1) begin
        errors++; $display("FAIL directed_rotate[%0d]: got %b/%b want %b/1", i, d1, v1, ev[i][1]);
      end
    end
  endtask
  task automatic test_back_to_back;
    drive(8'b00001111, 3'd1, 1'b0, 1'b1);
    checks++;
    if (d0 !== 8'b00000111 || v0 !== 1'b1 || d1 !== 8'b10000111) begin
      errors++; $display("FAIL b2b_right: got %b/%b rot %b want 00000111/1 rot 10000111", d0, v0, d1);
    end
    drive(8'b00001111, 3'd1, 1'b1, 1'b1);
    checks++;
    if (d0 !== 8'b00011110 || v0 !== 1'b1 || d1 !== 8'b00011110) begin
      errors++; $display("FAIL b2b_left: got %b/%b rot %b want 00011110/1", d0, v0, d1);
    end
    drive(8'hFF, 3'd5, 1'b0, 1'b0);
    checks++;
    if (d0 !== 8'b00011110 || v0 !== 1'b0 || d1 !== 8'b00011110 || v1 !== 1'b0) begin
      errors++; $display("FAIL hold: got %b/%b rot %b/%b want 00011110/0", d0, v0, d1, v1);
    end
  endtask
  task automatic test_sweep;
    logic [7:0] d, h0, h1;
    logic v;
    h0 = d0; h1 = d1;
    for (int rep = 0; rep < 6; rep++)
      for (int s = 0; s < 8; s++)
        for (int l = 0; l < 2; l++) begin
          d = 8'($urandom);
          v = ($urandom_range(0, 4) != 0);
          drive(d, 3'(s), l[0], v);
          if (v) begin
            h0 = model(d, s, l[0], 1'b0);
            h1 = model(d, s, l[0], 1'b1);
          end
          checks++;
          if (d0 !== h0 || v0 !== v) begin
            errors++; $display("FAIL sweep_shift d=%b n=%0d lr=%0d v=%b: got %b/%b want %b/%b", d, s, l, v, d0, v0, h0, v);
          end
          checks++;
          if (d1 !== h1 || v1 !== v) begin
            errors++; $display("FAIL sweep_rotate d=%b n=%0d lr=%0d v=%b: got %b/%b want %b/%b", d, s, l, v, d1, v1, h1, v);
          end
        end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
